// File: rtl/bellek.sv
// rtl/bellek.sv - memory stage: load/store on the data port, alignment, misaligned traps, stall
module bellek #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32,
  parameter int UOP_BIT   = 2*VERI_BIT + 10
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [UOP_BIT-1:0]   bellek_uop_i,
  output logic [UOP_BIT-1:0]   gy_uop_o,
  output logic                 duraklat_o,
  output logic                 veri_istek_gecerli_o,
  input  logic                 veri_istek_hazir_i,
  output logic                 veri_istek_yaz_o,
  output logic [ADRES_BIT-1:0] veri_istek_adres_o,
  output logic [VERI_BIT-1:0]  veri_istek_veri_o,
  output logic [3:0]           veri_istek_maske_o,
  input  logic                 veri_cevap_gecerli_i,
  input  logic [VERI_BIT-1:0]  veri_cevap_veri_i,
  output logic                 ddb_hizasiz_gecerli_o,
  output logic [3:0]           ddb_hizasiz_kod_o,
  output logic [ADRES_BIT-1:0] ddb_hizasiz_adres_o
);

  // uop layout: [0] valid, then RD, RS2, 4-bit memory opcode, remaining bits opaque
  localparam int UOP_VALID   = 0;
  localparam int UOP_RD      = 1;
  localparam int UOP_RS2     = 1 + VERI_BIT;
  localparam int UOP_BELLEK  = 1 + 2*VERI_BIT;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT} durum_t;

  durum_t durum, durum_sonraki;

  logic                 gir_gecerli;
  logic [VERI_BIT-1:0]  gir_rd;
  logic [VERI_BIT-1:0]  gir_rs2;
  logic [3:0]           gir_op;
  logic [ADRES_BIT-1:0] gir_adres;

  assign gir_gecerli = bellek_uop_i[UOP_VALID];
  assign gir_rd      = bellek_uop_i[UOP_RD +: VERI_BIT];
  assign gir_rs2     = bellek_uop_i[UOP_RS2 +: VERI_BIT];
  assign gir_op      = bellek_uop_i[UOP_BELLEK +: 4];
  assign gir_adres   = gir_rd[ADRES_BIT-1:0];

  logic bellek_op, yazma_op, hizasiz, basla;

  always_comb begin
    bellek_op = (gir_op >= OP_LB) && (gir_op <= OP_SW);
    yazma_op  = (gir_op >= OP_SB) && (gir_op <= OP_SW);
    hizasiz   = 1'b0;
    case (gir_op)
      OP_LH, OP_LHU, OP_SH: hizasiz = gir_adres[0];
      OP_LW, OP_SW:         hizasiz = (gir_adres[1:0] != 2'b00);
      default:              hizasiz = 1'b0;
    endcase
    basla = gir_gecerli && bellek_op && !hizasiz;
  end

  // store data is lane-replicated so the strobes alone select the bytes written
  logic [VERI_BIT-1:0] yaz_veri;
  logic [3:0]          yaz_maske;

  always_comb begin
    yaz_veri  = '0;
    yaz_maske = 4'b0000;
    case (gir_op)
      OP_SB: begin
        yaz_veri  = {4{gir_rs2[7:0]}};
        yaz_maske = 4'b0001 << gir_adres[1:0];
      end
      OP_SH: begin
        yaz_veri  = {2{gir_rs2[15:0]}};
        yaz_maske = gir_adres[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        yaz_veri  = gir_rs2;
        yaz_maske = 4'b1111;
      end
      default: begin
        yaz_veri  = '0;
        yaz_maske = 4'b0000;
      end
    endcase
  end

  logic [UOP_BIT-1:0]   uop_q;
  logic [3:0]           op_q;
  logic [ADRES_BIT-1:0] adres_q;
  logic [VERI_BIT-1:0]  veri_q;
  logic [3:0]           maske_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) durum <= BOSTA;
    else         durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOSTA: if (basla) durum_sonraki = ISTEK;
      ISTEK: begin
        if (veri_istek_hazir_i) durum_sonraki = (op_q >= OP_SB) ? BOSTA : YANIT;
      end
      YANIT: if (veri_cevap_gecerli_i) durum_sonraki = BOSTA;
      default: durum_sonraki = BOSTA;
    endcase
  end

  always_comb begin
    veri_istek_gecerli_o = (durum == ISTEK);
    duraklat_o           = (durum == ISTEK) || (durum == YANIT);
    veri_istek_yaz_o     = veri_istek_gecerli_o && (op_q >= OP_SB);
    veri_istek_adres_o   = veri_istek_gecerli_o ? {adres_q[ADRES_BIT-1:2], 2'b00} : '0;
    veri_istek_veri_o    = veri_istek_gecerli_o ? veri_q : '0;
    veri_istek_maske_o   = veri_istek_yaz_o ? maske_q : 4'b0000;
  end

  logic [7:0]          yuk_bayt;
  logic [15:0]         yuk_yarim;
  logic [VERI_BIT-1:0] yuk_sonuc;

  always_comb begin
    case (adres_q[1:0])
      2'd0:    yuk_bayt = veri_cevap_veri_i[7:0];
      2'd1:    yuk_bayt = veri_cevap_veri_i[15:8];
      2'd2:    yuk_bayt = veri_cevap_veri_i[23:16];
      default: yuk_bayt = veri_cevap_veri_i[31:24];
    endcase
    yuk_yarim = adres_q[1] ? veri_cevap_veri_i[31:16] : veri_cevap_veri_i[15:0];
    case (op_q)
      OP_LB:   yuk_sonuc = {{24{yuk_bayt[7]}}, yuk_bayt};
      OP_LBU:  yuk_sonuc = {24'd0, yuk_bayt};
      OP_LH:   yuk_sonuc = {{16{yuk_yarim[15]}}, yuk_yarim};
      OP_LHU:  yuk_sonuc = {16'd0, yuk_yarim};
      default: yuk_sonuc = veri_cevap_veri_i;
    endcase
  end

  logic [UOP_BIT-1:0] yazma_sonuc_uop;
  logic [UOP_BIT-1:0] yukleme_sonuc_uop;

  always_comb begin
    yazma_sonuc_uop                         = uop_q;
    yazma_sonuc_uop[UOP_VALID]              = 1'b1;
    yazma_sonuc_uop[UOP_RD +: VERI_BIT]     = '0;
    yukleme_sonuc_uop                       = uop_q;
    yukleme_sonuc_uop[UOP_VALID]            = 1'b1;
    yukleme_sonuc_uop[UOP_RD +: VERI_BIT]   = yuk_sonuc;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      uop_q                 <= '0;
      op_q                  <= 4'd0;
      adres_q               <= '0;
      veri_q                <= '0;
      maske_q               <= 4'b0000;
      gy_uop_o              <= '0;
      ddb_hizasiz_gecerli_o <= 1'b0;
      ddb_hizasiz_kod_o     <= 4'd0;
      ddb_hizasiz_adres_o   <= '0;
    end else begin
      gy_uop_o              <= '0;
      ddb_hizasiz_gecerli_o <= 1'b0;
      ddb_hizasiz_kod_o     <= 4'd0;
      ddb_hizasiz_adres_o   <= '0;
      case (durum)
        BOSTA: begin
          if (gir_gecerli && !bellek_op) begin
            gy_uop_o <= bellek_uop_i;
          end else if (gir_gecerli && hizasiz) begin
            ddb_hizasiz_gecerli_o <= 1'b1;
            ddb_hizasiz_kod_o     <= yazma_op ? 4'd6 : 4'd4;
            ddb_hizasiz_adres_o   <= gir_adres;
          end else if (basla) begin
            uop_q   <= bellek_uop_i;
            op_q    <= gir_op;
            adres_q <= gir_adres;
            veri_q  <= yaz_veri;
            maske_q <= yaz_maske;
          end
        end
        ISTEK: begin
          if (veri_istek_hazir_i && (op_q >= OP_SB)) gy_uop_o <= yazma_sonuc_uop;
        end
        YANIT: begin
          if (veri_cevap_gecerli_i) gy_uop_o <= yukleme_sonuc_uop;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bellek.md
Name: bellek

Overview:
- Memory stage of the in-order pipeline. Sits directly downstream of the execute stage and consumes its registered micro-op bus.
- Performs loads and stores on the data-memory port using a valid/ready request channel and a valid-only response channel.
- Aligns and extends load data, raises misaligned-access exceptions, and stalls upstream while an access is outstanding.
- Hands a registered micro-op to the writeback stage.

Parameters:
- ADRES_BIT, 32, data-memory address width.
- VERI_BIT, 32, data word width; fixed at 32 (4 byte lanes).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset.
- bellek_uop_i  in  UOP_BIT  micro-op from execute.
  - Fields used: UOP_VALID; UOP_RD (ALU result = effective address for memory ops, final result otherwise); UOP_RS2 (store data); UOP_BELLEK (4-bit memory opcode).
- gy_uop_o  out  UOP_BIT  registered micro-op to writeback.
- duraklat_o  out  1  stall request to execute; execute holds its output register while high.
- veri_istek_gecerli_o  out  1  data request valid.
- veri_istek_hazir_i  in  1  memory accepts request.
- veri_istek_yaz_o  out  1  1 = store, 0 = load.
- veri_istek_adres_o  out  ADRES_BIT  word-aligned address ({addr[31:2],2'b00}).
- veri_istek_veri_o  out  VERI_BIT  store data, lane-replicated.
- veri_istek_maske_o  out  4  byte write strobes; 4'b0000 for loads.
- veri_cevap_gecerli_i  in  1  load data valid.
- veri_cevap_veri_i  in  VERI_BIT  load word.
- ddb_hizasiz_gecerli_o  out  1  one-cycle misaligned-exception pulse.
- ddb_hizasiz_kod_o  out  4  exception code: 4 = load, 6 = store.
- ddb_hizasiz_adres_o  out  ADRES_BIT  faulting address (mtval).

Interface:
- One clock, clk_i.
- Reset rstn_i is asynchronous and active-low.

Behaviour:

UOP_BELLEK encoding:
- 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW.
- 9–15 are treated as NOP.

Reset (rstn_i low, asynchronous):
- State = BOSTA.
- gy_uop_o = 0, all request outputs = 0, duraklat_o = 0, ddb_* = 0.
- Reset mid-access abandons the access; a late response is ignored (state BOSTA).

FSM states: BOSTA, ISTEK, YANIT.

BOSTA:
- Input invalid → gy_uop_o valid bit 0 next cycle.
- Valid non-memory uop → copied to gy_uop_o next cycle; 1-cycle latency, no stall.
- Valid memory uop, misaligned (H with addr[0]=1; W with addr[1:0]≠0):
  - no request issued;
  - ddb_hizasiz_* asserted for 1 cycle (registered, next cycle);
  - gy_uop_o valid bit 0.
- Valid memory uop, aligned:
  - capture uop, address, mask and store data into internal registers;
  - go to ISTEK; gy_uop_o valid bit 0 next cycle.

ISTEK:
- veri_istek_gecerli_o = 1; all request fields come from internal registers and stay stable until the handshake.
- On veri_istek_hazir_i:
  - store → BOSTA; gy_uop_o = captured uop with UOP_RD = 0, valid = 1, next cycle;
  - load → YANIT.
- veri_cevap_gecerli_i is ignored in ISTEK.

YANIT:
- veri_istek_gecerli_o = 0.
- On veri_cevap_gecerli_i → BOSTA; gy_uop_o = captured uop with UOP_RD = extended load data, valid = 1, next cycle.
- The response can arrive at the earliest one cycle after the handshake cycle.

Stall and bubbles:
- duraklat_o = (state == ISTEK) || (state == YANIT), decoded combinationally from state.
- The uop execute presents during the stall is held and consumed in the first BOSTA cycle.
- gy_uop_o valid bit is 0 in every cycle not listed above (bubble).

Store formatting:
- SB: data = {4{rs2[7:0]}}, mask = 4'b0001 << addr[1:0].
- SH: data = {2{rs2[15:0]}}, mask = addr[1] ? 4'b1100 : 4'b0011.
- SW: data = rs2, mask = 4'b1111.

Load formatting:
- Select byte lane addr[1:0] (LB/LBU) or halfword addr[1] (LH/LHU) of veri_cevap_veri_i.
- LB/LH sign-extend; LBU/LHU zero-extend; LW uses the word as-is.

Throughput:
- Memory op minimum = 2 cycles busy (store with immediate hazir); load minimum = 3.

Test Plan:
1. Non-mem uop, RD=0x1234 → gy_uop_o valid with RD=0x1234 next cycle; duraklat_o never high.
2. SB, addr=0x103, rs2=0xAABBCCDD, hazir held low 2 cycles → veri_istek_gecerli_o high 3 cycles with adres=0x100, veri=0xDDDDDDDD, maske=4'b1000 stable; duraklat_o high throughout; gy_uop_o valid, RD=0, 1 cycle after handshake.
3. LB, addr=0x202, response 0x00800000 3 cycles after handshake → RD=0xFFFFFF80. Same with LBU → 0x00000080. LH, addr=0x202, response 0x80010000 → 0xFFFF8001.
4. LW, addr=0x301 → no request; ddb_hizasiz_gecerli_o pulses, kod=4, adres=0x301. SH, addr=0x3 → kod=6. gy_uop_o valid=0 in both.
5. Back-to-back LW then non-mem uop (RD=0x55) → the non-mem uop is held at the input during the stall and appears on gy_uop_o the cycle after the LW result.
6. rstn_i asserted in YANIT, response arriving after release → state BOSTA, no gy_uop_o valid, all outputs 0.
